// File: rtl/data_memory_responder_pkg.sv
// Shared widths, FSM encoding and counter helper for the data-memory responder.
package data_memory_responder_pkg;

    localparam int DATA_SIZE      = 16;
    localparam int ADDRESS_SIZE   = 10;
    localparam int MEM_COUNT_SIZE = 16;

    typedef enum logic {
        MEM_STATE_CLEAR = 1'b0,
        MEM_STATE_SERVE = 1'b1
    } mem_state_t;

    function automatic logic [MEM_COUNT_SIZE-1:0] sat_inc(input logic [MEM_COUNT_SIZE-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Synchronous single-port RAM, write-first read port, no reset.
module sync_ram_sp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: clear sweep after reset, then one load/store per cycle
// with range checking, sticky error flag and saturating access counters.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_SIZE,
    parameter int ADDRESS_WIDTH  = ADDRESS_SIZE,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      read,
    input  logic                      write,
    input  logic [ADDRESS_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]     data_out,
    output logic [DATA_WIDTH-1:0]     data_in,
    output logic                      ready,
    output logic                      error,
    output logic [MEM_COUNT_SIZE-1:0] read_count,
    output logic [MEM_COUNT_SIZE-1:0] write_count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    mem_state_t            state, state_next;
    logic [PTR_WIDTH-1:0]  ptr;
    logic                  in_range;
    logic                  ram_we;
    logic [PTR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
    logic                  acc_read, acc_write, load_ram, load_zero, bad;
    logic                  ram_valid;
    logic [DATA_WIDTH-1:0] data_q;

    assign in_range = (32'(address) < DEPTH);

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_addr   = address[PTR_WIDTH-1:0];
        ram_wdata  = data_out;
        acc_read   = 1'b0;
        acc_write  = 1'b0;
        load_ram   = 1'b0;
        load_zero  = 1'b0;
        bad        = 1'b0;
        case (state)
            MEM_STATE_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = ptr;
                ram_wdata = '0;
                bad       = read | write;
                if (ptr == LAST_PTR) state_next = MEM_STATE_SERVE;
            end
            default: begin
                if (read | write) begin
                    if (!in_range) begin
                        bad       = 1'b1;
                        load_zero = read;
                    end else begin
                        ram_we    = write;
                        acc_write = write;
                        acc_read  = read & ~write;
                        load_ram  = read;
                        bad       = read & write;
                    end
                end
            end
        endcase
        if (reset) ram_we = 1'b0;
    end

    sync_ram_sp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(PTR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // The RAM output changes every cycle, so data_q latches whatever is being
    // presented; ram_valid selects the fresh RAM word only after an accepted load.
    assign data_in = ram_valid ? ram_rdata : data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= (CLEAR_ON_RESET != 0) ? MEM_STATE_CLEAR : MEM_STATE_SERVE;
            ptr         <= '0;
            ready       <= 1'b0;
            error       <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
            ram_valid   <= 1'b0;
            data_q      <= '0;
        end else begin
            state <= state_next;
            ready <= (state_next == MEM_STATE_SERVE);
            if (state == MEM_STATE_CLEAR) ptr <= ptr + 1'b1;
            if (bad) error <= 1'b1;
            if (acc_read)  read_count  <= sat_inc(read_count);
            if (acc_write) write_count <= sat_inc(write_count);
            ram_valid <= load_ram;
            data_q    <= load_zero ? '0 : data_in;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed scoreboard bench for data_memory_responder at DEPTH=16.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [9:0]  address = '0;
    logic [15:0] data_out = '0;
    logic [15:0] data_in;
    logic        ready;
    logic        error;
    logic [15:0] read_count;
    logic [15:0] write_count;

    data_memory_responder #(
        .DATA_WIDTH    (16),
        .ADDRESS_WIDTH (10),
        .DEPTH         (16),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .data_out   (data_out),
        .data_in    (data_in),
        .ready      (ready),
        .error      (error),
        .read_count (read_count),
        .write_count(write_count)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic [15:0] m_mem [16];
    logic [15:0] m_din;
    logic [15:0] m_rc, m_wc;
    logic        m_err, m_serve;
    logic [15:0] sb_q [$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_din   = '0;
        m_rc    = '0;
        m_wc    = '0;
        m_err   = 1'b0;
        m_serve = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset(input int unsigned cycles);
        reset = 1'b1;
        for (int unsigned i = 0; i < cycles; i++) tick();
        chk("rst_data_in", data_in, 0);
        chk("rst_ready", ready, 0);
        chk("rst_error", error, 0);
        chk("rst_read_count", read_count, 0);
        chk("rst_write_count", write_count, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_sweep(input int unsigned exp_low);
        int unsigned n;
        n = 0;
        while (!ready && n < 100) begin
            n++;
            tick();
        end
        chk("sweep_len", n, exp_low);
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_serve = 1'b1;
    endtask

    task automatic do_access(input logic r, input logic w, input logic [9:0] a, input logic [15:0] d);
        read = r; write = w; address = a; data_out = d;
        if (r | w) begin
            if (!m_serve) begin
                m_err = 1'b1;
            end else if (a >= 10'd16) begin
                m_err = 1'b1;
                if (r) m_din = '0;
            end else if (r && w) begin
                m_mem[a[3:0]] = d;
                m_din = d;
                m_err = 1'b1;
                if (m_wc != 16'hFFFF) m_wc++;
            end else if (w) begin
                m_mem[a[3:0]] = d;
                if (m_wc != 16'hFFFF) m_wc++;
            end else begin
                m_din = m_mem[a[3:0]];
                if (m_rc != 16'hFFFF) m_rc++;
            end
        end
        sb_q.push_back(m_din);
        tick();
        read = 1'b0; write = 1'b0;
        chk("data_in", data_in, sb_q.pop_front());
        chk("read_count", read_count, m_rc);
        chk("write_count", write_count, m_wc);
        chk("error", error, m_err);
        chk("ready", ready, m_serve);
    endtask

    initial begin
        model_reset();
        // 1: reset, sweep length, cleared read
        do_reset(2);
        wait_sweep(16);
        do_access(1, 0, 10'd5, 16'h0000);

        // 2: write then read back
        do_access(0, 1, 10'd3, 16'hBEEF);
        do_access(1, 0, 10'd3, 16'h0000);
        chk("t2_wc", write_count, 1);
        chk("t2_err", error, 0);

        // idle holds data_in
        do_access(0, 0, 10'd0, 16'h0000);

        // 3: simultaneous read and write
        do_access(1, 1, 10'd7, 16'h1234);
        do_access(1, 0, 10'd7, 16'h0000);

        // 4: out-of-range accesses; aliased word stays clear
        do_access(0, 1, 10'd20, 16'hAAAA);
        do_access(1, 0, 10'd20, 16'h0000);
        do_access(1, 0, 10'd4, 16'h0000);

        // 5a: write late in sweep is ignored
        do_reset(2);
        for (int i = 0; i < 13; i++) tick();
        do_access(0, 1, 10'd2, 16'h7777);
        wait_sweep(2);
        do_access(1, 0, 10'd2, 16'h0000);

        // 5b: write at sweep cycle 5, reset at sweep cycle 8
        do_reset(2);
        for (int i = 0; i < 4; i++) tick();
        do_access(0, 1, 10'd9, 16'h5555);
        tick();
        tick();
        do_reset(1);
        wait_sweep(16);
        do_access(1, 0, 10'd9, 16'h0000);

        // 6: read counter saturation
        do_access(0, 1, 10'd3, 16'hBEEF);
        for (int i = 0; i < 65537; i++) do_access(1, 0, 10'd3, 16'h0000);
        chk("t6_rc_sat", read_count, 16'hFFFF);
        do_access(1, 0, 10'd11, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
